// File: rtl/video_pkg.sv
// Shared geometry and pipeline constants for the text-mode video renderer.
package video_pkg;

    localparam int unsigned CELL_W   = 12;
    localparam int unsigned CELL_H   = 16;
    localparam int unsigned GLYPH_W  = 6;
    localparam int unsigned GLYPH_H  = 8;
    localparam int unsigned VRAM_AW  = 11;
    localparam int unsigned FONT_AW  = 10;
    localparam int unsigned PIPE_LAT = 5;

    // Per-pixel data that travels alongside the memory fetches.
    typedef struct packed {
        logic       active;
        logic [2:0] bitsel;
        logic       cursor;
    } side_t;

endpackage

// File: rtl/text_cell_counter.sv
// Horizontal cell position tracker: sub-pixel and column counters that reload
// at the first window column of every line and advance only inside the window.
module text_cell_counter
    import video_pkg::*;
#(
    parameter int unsigned H_OFFSET = 16,
    parameter int unsigned COLS     = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [10:0] i_counter_x,
    output logic [2:0]  o_bitsel,
    output logic [5:0]  o_col,
    output logic        o_x_active
);

    logic [3:0] r_subx;
    logic [5:0] r_col;
    logic       w_load;
    logic [3:0] w_subx;
    logic [5:0] w_col;

    // The load value is applied combinationally so the H_OFFSET pixel itself is cell 0.
    always_comb begin
        w_load     = (i_counter_x == 11'(H_OFFSET));
        o_x_active = (i_counter_x >= 11'(H_OFFSET)) &&
                     (i_counter_x < 11'(H_OFFSET + COLS * CELL_W));
        w_subx     = w_load ? '0 : r_subx;
        w_col      = w_load ? '0 : r_col;
        o_bitsel   = w_subx[3:1];
        o_col      = w_col;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_subx <= '0;
            r_col  <= '0;
        end else if (o_x_active) begin
            if (w_subx == 4'(CELL_W - 1)) begin
                r_subx <= '0;
                r_col  <= w_col + 6'd1;
            end else begin
                r_subx <= w_subx + 4'd1;
                r_col  <= w_col;
            end
        end
    end

endmodule

// File: rtl/video_text_renderer.sv
// Text-mode pixel generator: VRAM -> font ROM -> pixel, 5-clock latency, syncs delayed to match.
// Optional blinking underline cursor is built when VIDEO_CURSOR_EN is defined.
module video_text_renderer
    import video_pkg::*;
#(
    parameter int unsigned H_OFFSET     = 16,
    parameter int unsigned V_OFFSET     = 100,
    parameter int unsigned COLS         = 64,
    parameter int unsigned ROWS         = 25,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        counter_x,
    input  logic [10:0]        counter_y,
    input  logic               in_display,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    input  logic [5:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    output logic               pixel,
    output logic               h_sync_out,
    output logic               v_sync_out
);

    logic [2:0]            w_bitsel;
    logic [5:0]            w_col;
    logic                  w_x_active;
    logic [7:0]            w_half_y;
    logic [4:0]            w_row;
    logic [2:0]            w_gline;
    logic                  w_y_active;
    logic                  w_cursor_hit;
    side_t                 w_side;
    logic                  w_glyph_bit;

    logic [VRAM_AW-1:0]    r_vram_addr;
    logic [FONT_AW-1:0]    r_font_addr;
    side_t [3:0]           r_side;
    logic [1:0][2:0]       r_gline;
    logic [1:0]            r_inv;
    logic [PIPE_LAT-3:0]   r_disp;
    logic [PIPE_LAT-2:0]   r_hs;
    logic [PIPE_LAT-2:0]   r_vs;
    logic                  r_pixel;

    text_cell_counter #(
        .H_OFFSET (H_OFFSET),
        .COLS     (COLS)
    ) u_cell_counter (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_counter_x (counter_x),
        .o_bitsel    (w_bitsel),
        .o_col       (w_col),
        .o_x_active  (w_x_active)
    );

    // Line pairs map to one glyph row, so only ay >> 1 is ever needed.
    always_comb begin
        w_half_y   = 8'((counter_y - 11'(V_OFFSET)) >> 1);
        w_row      = w_half_y[7:3];
        w_gline    = w_half_y[2:0];
        w_y_active = (counter_y >= 11'(V_OFFSET)) &&
                     (counter_y < 11'(V_OFFSET + ROWS * CELL_H));
    end

`ifdef VIDEO_CURSOR_EN
    localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);

    logic               r_vs_prev;
    logic [FRAME_W-1:0] r_frame;
    logic               r_blink_hidden;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev      <= 1'b0;
            r_frame        <= '0;
            r_blink_hidden <= 1'b0;
        end else begin
            r_vs_prev <= v_sync_in;
            if (v_sync_in && !r_vs_prev) begin
                if (r_frame == FRAME_W'(BLINK_FRAMES - 1)) begin
                    r_frame        <= '0;
                    r_blink_hidden <= ~r_blink_hidden;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cursor_hit = (w_col == cursor_col) && (w_row == cursor_row) &&
                       (w_gline == 3'(GLYPH_H - 1)) && !r_blink_hidden;
    end
`else
    logic w_cursor_unused;

    always_comb begin
        w_cursor_hit    = 1'b0;
        w_cursor_unused = ^{cursor_col, cursor_row, 32'(BLINK_FRAMES)};
    end
`endif

    always_comb begin
        w_side.active = w_x_active & w_y_active;
        w_side.bitsel = w_bitsel;
        w_side.cursor = w_cursor_hit;
        w_glyph_bit   = font_data[3'(GLYPH_W - 1) - r_side[3].bitsel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vram_addr <= '0;
            r_font_addr <= '0;
            r_side      <= '0;
            r_gline     <= '0;
            r_inv       <= '0;
            r_disp      <= '0;
            r_hs        <= '0;
            r_vs        <= '0;
            r_pixel     <= 1'b0;
        end else begin
            if (w_side.active) begin
                r_vram_addr <= VRAM_AW'(32'(w_row) * COLS + 32'(w_col));
            end
            // vram_data belongs to the fetch issued two edges earlier (stage 2 side data).
            if (r_side[1].active) begin
                r_font_addr <= {vram_data[6:0], r_gline[1]};
            end
            r_side  <= {r_side[2:0], w_side};
            r_gline <= {r_gline[0], w_gline};
            r_inv   <= {r_inv[0], vram_data[7]};
            r_disp  <= {r_disp[PIPE_LAT-4:0], in_display};
            r_hs    <= {r_hs[PIPE_LAT-3:0], h_sync_in};
            r_vs    <= {r_vs[PIPE_LAT-3:0], v_sync_in};
            r_pixel <= r_disp[PIPE_LAT-3] & r_side[3].active &
                       (w_glyph_bit ^ r_inv[1] ^ r_side[3].cursor);
        end
    end

    always_comb begin
        vram_addr  = r_vram_addr;
        font_addr  = r_font_addr;
        pixel      = r_pixel;
        h_sync_out = r_hs[PIPE_LAT-2];
        v_sync_out = r_vs[PIPE_LAT-2];
    end

endmodule

// File: tb/tb_video_text_renderer.sv
// Self-checking bench for video_text_renderer: a cycle-level reference model of the
// text window (arithmetic on x/y) is compared against pixel and delayed syncs.
module tb_video_text_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] counter_x, counter_y;
    logic        in_display, h_sync_in, v_sync_in;
    logic [10:0] vram_addr;
    logic [7:0]  vram_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        pixel, h_sync_out, v_sync_out;

    always #5 clk = ~clk;

    video_text_renderer #(
        .H_OFFSET     (16),
        .V_OFFSET     (100),
        .COLS         (64),
        .ROWS         (25),
        .BLINK_FRAMES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .in_display (in_display),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .pixel      (pixel),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out)
    );

    logic [7:0] vram [0:2047];
    logic [7:0] font [0:1023];

    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    typedef struct {
        bit pix;
        bit hs;
        bit vs;
        bit chk;
    } exp_t;

    typedef struct {
        int unsigned col;
        int unsigned row;
        int unsigned yin;
        int unsigned exp_addr;
        int unsigned exp_gl;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[6];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned prev_x, prev_y;
    bit          prev_valid = 1'b0;
    bit          last_vs = 1'b0;
    int unsigned n_vrise = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)",
                     name, act, expv, prev_x, prev_y, $time);
        end
    endtask

    function automatic bit disp_rule(input int unsigned x, input int unsigned y);
        return (x < 800) && (y < 600);
    endfunction

    function automatic bit hs_rule(input int unsigned x);
        return (x >= 816) && (x < 896);
    endfunction

    function automatic bit vs_rule(input int unsigned y);
        return (y >= 601) && (y < 605);
    endfunction

    // Pixel value a text screen should show at (x,y), ignoring display enable.
    function automatic bit ref_pixel(input int unsigned x, input int unsigned y);
        int unsigned col, sub, row, gl;
        logic [7:0]  code, glyph;
        bit          cur;
        if (x < 16 || x >= 16 + 64 * 12 || y < 100 || y >= 100 + 25 * 16) return 1'b0;
        col   = (x - 16) / 12;
        sub   = (x - 16) % 12;
        row   = (y - 100) / 16;
        gl    = ((y - 100) % 16) / 2;
        code  = vram[row * 64 + col];
        glyph = font[int'(code & 8'h7f) * 8 + gl];
        cur   = 1'b0;
`ifdef VIDEO_CURSOR_EN
        cur = (col == cursor_col) && (row == cursor_row) && (gl == 7) && ((n_vrise / 16) % 2 == 0);
`endif
        return glyph[5 - sub / 2] ^ code[7] ^ cur;
    endfunction

    task automatic tick(input int unsigned x, input int unsigned y, input bit chk);
        exp_t e;
        bit   din, hin, vin;
        @(posedge clk);
        #1;
        if (q.size() == 5) begin
            e = q.pop_front();
            if (e.chk) begin
                check("pixel", pixel, e.pix);
                check("h_sync_out", h_sync_out, e.hs);
                check("v_sync_out", v_sync_out, e.vs);
            end
        end
        din = prev_valid && disp_rule(prev_x, prev_y);
        hin = prev_valid && hs_rule(prev_x);
        vin = prev_valid && vs_rule(prev_y);
        counter_x  = 11'(x);
        counter_y  = 11'(y);
        in_display = din;
        h_sync_in  = hin;
        v_sync_in  = vin;
        e.pix = disp_rule(x, y) && ref_pixel(x, y);
        e.hs  = hs_rule(x);
        e.vs  = vs_rule(y);
        e.chk = chk;
        q.push_back(e);
        if (vin && !last_vs) n_vrise++;
        last_vs    = vin;
        prev_x     = x;
        prev_y     = y;
        prev_valid = 1'b1;
    endtask

    task automatic run_line(input int unsigned y);
        for (int x = 0; x < 900; x++) tick(x, y, 1'b1);
    endtask

    task automatic drain();
        repeat (6) tick(1000, 700, 1'b1);
    endtask

    task automatic do_reset(input int unsigned ncyc, input int unsigned x0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        counter_x  = 11'(x0);
        in_display = 1'b0;
        h_sync_in  = 1'b0;
        v_sync_in  = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            check("reset outputs", {vram_addr, font_addr, pixel, h_sync_out, v_sync_out}, 0);
            counter_x = counter_x + 11'd1;
        end
        reset = 1'b0;
        q.delete();
        repeat (5) q.push_back('{pix: 1'b0, hs: 1'b0, vs: 1'b0, chk: 1'b1});
        prev_valid = 1'b0;
        last_vs    = 1'b0;
        n_vrise    = 0;
    endtask

    initial begin
        int unsigned yl[8];
        int unsigned tx, ty;

        vecs[0] = '{col: 5,  row: 3,  yin: 0,  exp_addr: 197,  exp_gl: 0};
        vecs[1] = '{col: 0,  row: 0,  yin: 0,  exp_addr: 0,    exp_gl: 0};
        vecs[2] = '{col: 63, row: 24, yin: 15, exp_addr: 1599, exp_gl: 7};
        vecs[3] = '{col: 10, row: 1,  yin: 5,  exp_addr: 74,   exp_gl: 2};
        vecs[4] = '{col: 63, row: 0,  yin: 9,  exp_addr: 63,   exp_gl: 4};
        vecs[5] = '{col: 31, row: 12, yin: 2,  exp_addr: 799,  exp_gl: 1};

        reset      = 1'b1;
        counter_x  = 11'd1000;
        counter_y  = 11'd700;
        in_display = 1'b0;
        h_sync_in  = 1'b0;
        v_sync_in  = 1'b0;
        cursor_col = 6'd2;
        cursor_row = 5'd0;
        for (int i = 0; i < 2048; i++) vram[i] = 8'h41;
        for (int i = 0; i < 1024; i++) font[i] = 8'h3F;

        do_reset(4, 1000);

        // Uniform solid glyphs: window edges, first lit pixel latency, syncs.
        yl = '{99, 100, 101, 114, 115, 499, 500, 602};
        foreach (yl[i]) run_line(yl[i]);
        drain();

        // Inverse video in cell (0,0) over a narrow glyph column.
        for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
        for (int i = 0; i < 1024; i++) font[i] = 8'h00;
        vram[0] = 8'h81;
        for (int i = 8; i < 16; i++) font[i] = 8'h20;
        yl = '{100, 107, 115, 116, 99, 130, 131, 132};
        for (int i = 0; i < 4; i++) run_line(yl[i]);
        drain();

        // Address table against random memory contents.
        for (int i = 0; i < 2048; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
        foreach (vecs[v]) begin
            ty = 100 + 16 * vecs[v].row + vecs[v].yin;
            tx = 16 + 12 * vecs[v].col;
            for (int x = 0; x < 900; x++) begin
                tick(x, ty, 1'b1);
                if (x == tx + 1) check("vram_addr", vram_addr, vecs[v].exp_addr);
                if (x == tx + 3)
                    check("font_addr", font_addr,
                          int'(vram[vecs[v].exp_addr] & 8'h7f) * 8 + vecs[v].exp_gl);
            end
        end
        drain();

        // Random lines with a random cursor position.
        cursor_col = 6'($urandom_range(63, 0));
        cursor_row = 5'($urandom_range(24, 0));
        for (int i = 0; i < 6; i++) run_line($urandom_range(505, 95));
        run_line(100 + 16 * cursor_row + 14);
        run_line(100 + 16 * cursor_row + 15);
        drain();

        // Reset in mid-line: checked zero during reset, unchecked rest of line, correct after.
        for (int x = 0; x < 300; x++) tick(x, 140, 1'b1);
        do_reset(3, 300);
        for (int x = 304; x < 900; x++) tick(x, 140, 1'b0);
        run_line(141);
        run_line(142);
        drain();

        // Cursor blink over 34 short frames with an empty font.
        for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
        for (int i = 0; i < 1024; i++) font[i] = 8'h00;
        cursor_col = 6'd2;
        cursor_row = 5'd0;
        drain();
        for (int f = 0; f < 34; f++) begin
            for (int x = 0; x < 60; x++) tick(x, 114, 1'b1);
            for (int x = 0; x < 60; x++) tick(x, 115, 1'b1);
            tick(1000, 602, 1'b1);
            tick(1000, 602, 1'b1);
            tick(1000, 700, 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
